// File: rtl/pred_rf_pkg.sv
// Predicate register file package.
// Holds the default geometry (warps, registers per warp, lanes per warp),
// the derived index widths for that geometry, and the controller state
// encoding shared by the top level.
package pred_rf_pkg;

    localparam int DEF_NUM_WARPS = 8;
    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_NUM_LANES = 8;

    localparam int DEF_WARP_W = $clog2(DEF_NUM_WARPS);
    localparam int DEF_REG_W  = $clog2(DEF_NUM_REGS);
    localparam int DEF_IDX_W  = DEF_WARP_W + DEF_REG_W;

    // INIT  : full-array clear after reset
    // IDLE  : normal operation, writes and clear requests accepted
    // CLEAR : zeroing all registers of one warp
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Width of the flat {warp, reg} entry index.
    function automatic int entry_idx_w(input int warps, input int regs);
        return $clog2(warps) + $clog2(regs);
    endfunction

endpackage

// File: rtl/pred_rf_bank.sv
// Predicate storage bank: NUM_WARPS*NUM_REGS entries of NUM_LANES bits,
// addressed by a flat {warp, reg} index.
// Ports:
//   clk, rst              clock, synchronous active-high reset (read regs only)
//   we / waddr / wdata    one per-lane masked write port
//   re_N / raddr_N        read lane enable and index, ports 0 and 1
//   rdata_N / rvalid_N    registered read data and valid, ports 0 and 1
// A read of the entry being written in the same cycle returns the new data
// on the written lanes and the stored data on the others.
module pred_rf_bank
    import pred_rf_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int IDX_W     = entry_idx_w(NUM_WARPS, NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [NUM_LANES-1:0] wdata,
    input  logic [NUM_LANES-1:0] re_0,
    input  logic [IDX_W-1:0]     raddr_0,
    input  logic [NUM_LANES-1:0] re_1,
    input  logic [IDX_W-1:0]     raddr_1,
    output logic [NUM_LANES-1:0] rdata_0,
    output logic                 rvalid_0,
    output logic [NUM_LANES-1:0] rdata_1,
    output logic                 rvalid_1
);

    localparam int DEPTH = NUM_WARPS * NUM_REGS;

    logic [NUM_LANES-1:0] mem [DEPTH];

    logic [NUM_LANES-1:0] byp_0_p0;
    logic [NUM_LANES-1:0] byp_1_p0;
    logic [NUM_LANES-1:0] rdata_0_p1;
    logic [NUM_LANES-1:0] rdata_1_p1;
    logic                 vld_0_p1;
    logic                 vld_1_p1;

    // Lane-wise merge of new data over old data under a write mask.
    function automatic logic [NUM_LANES-1:0] lane_merge(
        input logic [NUM_LANES-1:0] old_d,
        input logic [NUM_LANES-1:0] new_d,
        input logic [NUM_LANES-1:0] mask
    );
        return (new_d & mask) | (old_d & ~mask);
    endfunction

    always_ff @(posedge clk) begin
        if (|we) begin
            mem[waddr] <= lane_merge(mem[waddr], wdata, we);
        end
    end

    // ---- p0: array lookup with same-cycle write bypass ----
    always_comb begin
        byp_0_p0 = mem[raddr_0];
        byp_1_p0 = mem[raddr_1];
        if (raddr_0 == waddr) begin
            byp_0_p0 = lane_merge(mem[raddr_0], wdata, we);
        end
        if (raddr_1 == waddr) begin
            byp_1_p0 = lane_merge(mem[raddr_1], wdata, we);
        end
    end

    // ---- p1: registered read outputs, disabled lanes forced to zero ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_0_p1   <= 1'b0;
            vld_1_p1   <= 1'b0;
            rdata_0_p1 <= '0;
            rdata_1_p1 <= '0;
        end else begin
            vld_0_p1   <= |re_0;
            vld_1_p1   <= |re_1;
            rdata_0_p1 <= byp_0_p0 & re_0;
            rdata_1_p1 <= byp_1_p0 & re_1;
        end
    end

    assign rdata_0  = rdata_0_p1;
    assign rvalid_0 = vld_0_p1;
    assign rdata_1  = rdata_1_p1;
    assign rvalid_1 = vld_1_p1;

endmodule

// File: rtl/predicate_register_file.sv
// Predicate register file: per-warp, per-lane predicate storage with two
// registered read ports, one lane-masked write port and a clear engine.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   read_en_N/raddr_N/rwarp_N       read lane enable, register, warp (N=0,1)
//   write_en/waddr/wwarp/wdata      lane-masked write
//   clear_req/clear_warp            zero every register of one warp
//   busy                            INIT or CLEAR running; writes/clears ignored
//   rdata_N/rvalid_N                read data and valid, one cycle after request
// After reset the controller walks every entry (warp-major) writing zero;
// a single-warp clear walks the registers of the latched warp the same way.
// Both engines borrow the bank write port, which is why user writes are
// dropped while busy.
module predicate_register_file
    import pred_rf_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_LANES = DEF_NUM_LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         read_en_0,
    input  logic [$clog2(NUM_REGS)-1:0]  raddr_0,
    input  logic [$clog2(NUM_WARPS)-1:0] rwarp_0,
    input  logic [NUM_LANES-1:0]         read_en_1,
    input  logic [$clog2(NUM_REGS)-1:0]  raddr_1,
    input  logic [$clog2(NUM_WARPS)-1:0] rwarp_1,
    input  logic [NUM_LANES-1:0]         write_en,
    input  logic [$clog2(NUM_REGS)-1:0]  waddr,
    input  logic [$clog2(NUM_WARPS)-1:0] wwarp,
    input  logic [NUM_LANES-1:0]         wdata,
    input  logic                         clear_req,
    input  logic [$clog2(NUM_WARPS)-1:0] clear_warp,
    output logic                         busy,
    output logic [NUM_LANES-1:0]         rdata_0,
    output logic                         rvalid_0,
    output logic [NUM_LANES-1:0]         rdata_1,
    output logic                         rvalid_1
);

    localparam int WARP_W = $clog2(NUM_WARPS);
    localparam int REG_W  = $clog2(NUM_REGS);
    localparam int IDX_W  = WARP_W + REG_W;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic [WARP_W-1:0]  clr_warp, clr_warp_nxt;

    logic [NUM_LANES-1:0] bank_we;
    logic [IDX_W-1:0]     bank_waddr;
    logic [NUM_LANES-1:0] bank_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            clr_warp <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_warp <= clr_warp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_warp_nxt = clr_warp;
        bank_we      = '0;
        bank_waddr   = {wwarp, waddr};
        bank_wdata   = wdata;
        case (state)
            ST_INIT: begin
                bank_we    = '1;
                bank_waddr = cnt;
                bank_wdata = '0;
                // Power-of-2 depth: the increment wraps to 0 on the last entry.
                cnt_nxt    = cnt + IDX_W'(1);
                if (cnt == '1) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                bank_we = write_en;
                if (clear_req) begin
                    clr_warp_nxt = clear_warp;
                    cnt_nxt      = '0;
                    state_nxt    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Only the register field of cnt walks here; the warp comes
                // from the latched request so other warps are never touched.
                bank_we    = '1;
                bank_waddr = {clr_warp, cnt[REG_W-1:0]};
                bank_wdata = '0;
                if (cnt[REG_W-1:0] == '1) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    pred_rf_bank #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS),
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (bank_we),
        .waddr    (bank_waddr),
        .wdata    (bank_wdata),
        .re_0     (read_en_0),
        .raddr_0  ({rwarp_0, raddr_0}),
        .re_1     (read_en_1),
        .raddr_1  ({rwarp_1, raddr_1}),
        .rdata_0  (rdata_0),
        .rvalid_0 (rvalid_0),
        .rdata_1  (rdata_1),
        .rvalid_1 (rvalid_1)
    );

endmodule

// File: tb/tb_predicate_register_file.sv
// Testbench for predicate_register_file (default geometry 8 warps x 32 regs
// x 8 lanes). Reads push their expected data and due cycle into a per-port
// queue; a monitor on the falling edge pops and compares whenever rvalid is
// seen, and flags missing or unexpected responses.
module tb_predicate_register_file;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] read_en_0, read_en_1;
    logic [4:0] raddr_0, raddr_1;
    logic [2:0] rwarp_0, rwarp_1;
    logic [7:0] write_en;
    logic [4:0] waddr;
    logic [2:0] wwarp;
    logic [7:0] wdata;
    logic       clear_req;
    logic [2:0] clear_warp;
    logic       busy;
    logic [7:0] rdata_0, rdata_1;
    logic       rvalid_0, rvalid_1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    predicate_register_file dut (
        .clk        (clk),
        .rst        (rst),
        .read_en_0  (read_en_0),
        .raddr_0    (raddr_0),
        .rwarp_0    (rwarp_0),
        .read_en_1  (read_en_1),
        .raddr_1    (raddr_1),
        .rwarp_1    (rwarp_1),
        .write_en   (write_en),
        .waddr      (waddr),
        .wwarp      (wwarp),
        .wdata      (wdata),
        .clear_req  (clear_req),
        .clear_warp (clear_warp),
        .busy       (busy),
        .rdata_0    (rdata_0),
        .rvalid_0   (rvalid_0),
        .rdata_1    (rdata_1),
        .rvalid_1   (rvalid_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid_0 === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL rd0_unexpected: rvalid_0=1 data=%h, no read pending (cyc %0d)", rdata_0, cyc);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    if (rdata_0 !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL rd0_data: got %h at cyc %0d, want %h at cyc %0d", rdata_0, cyc, e.data, e.due);
                    end
                end
            end else begin
                checks++;
                if (rvalid_0 !== 1'b0 || rdata_0 !== 8'h00) begin
                    errors++;
                    $display("FAIL rd0_idle: rvalid_0=%b rdata_0=%h, want 0/00", rvalid_0, rdata_0);
                end
                if (q0.size() != 0 && q0[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rd0_missing: no rvalid_0 at cyc %0d, want data %h", cyc, q0[0].data);
                    void'(q0.pop_front());
                end
            end
            if (rvalid_1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL rd1_unexpected: rvalid_1=1 data=%h, no read pending (cyc %0d)", rdata_1, cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    if (rdata_1 !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL rd1_data: got %h at cyc %0d, want %h at cyc %0d", rdata_1, cyc, e.data, e.due);
                    end
                end
            end else begin
                checks++;
                if (rvalid_1 !== 1'b0 || rdata_1 !== 8'h00) begin
                    errors++;
                    $display("FAIL rd1_idle: rvalid_1=%b rdata_1=%h, want 0/00", rvalid_1, rdata_1);
                end
                if (q1.size() != 0 && q1[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rd1_missing: no rvalid_1 at cyc %0d, want data %h", cyc, q1[0].data);
                    void'(q1.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read_en_0  = '0; raddr_0 = '0; rwarp_0 = '0;
        read_en_1  = '0; raddr_1 = '0; rwarp_1 = '0;
        write_en   = '0; waddr   = '0; wwarp   = '0; wdata = '0;
        clear_req  = 1'b0; clear_warp = '0;
    endtask

    task automatic step();
        tick();
        idle_inputs();
    endtask

    task automatic rd0(input int w, input int r, input logic [7:0] en, input logic [7:0] exp_d);
        exp_t e;
        rwarp_0 = 3'(w); raddr_0 = 5'(r); read_en_0 = en;
        e.due = cyc + 1; e.data = exp_d;
        q0.push_back(e);
    endtask

    task automatic rd1(input int w, input int r, input logic [7:0] en, input logic [7:0] exp_d);
        exp_t e;
        rwarp_1 = 3'(w); raddr_1 = 5'(r); read_en_1 = en;
        e.due = cyc + 1; e.data = exp_d;
        q1.push_back(e);
    endtask

    task automatic wr(input int w, input int r, input logic [7:0] en, input logic [7:0] d);
        wwarp = 3'(w); waddr = 5'(r); write_en = en; wdata = d;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Count cycles busy stays high, bounded.
    task automatic busy_cycles(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        // Reset state: busy high, read outputs cleared.
        checks++;
        if (busy !== 1'b1 || rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0 ||
            rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b rv0=%b rv1=%b rd0=%h rd1=%h, want 1/0/0/00/00",
                     busy, rvalid_0, rvalid_1, rdata_0, rdata_1);
        end
        rst = 1'b0;
        busy_cycles(n);
        check_int("init_busy_cycles", n, 256);

        // Every entry zero after INIT.
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++) begin
                rd0(w, r, 8'hFF, 8'h00);
                step();
            end

        // Plain write then read; partial-lane read on port 1.
        wr(3, 5, 8'hFF, 8'hA5);
        step();
        rd0(3, 5, 8'hFF, 8'hA5);
        rd1(3, 5, 8'h0F, 8'h05);
        step();

        // Same-cycle write/read bypass, then confirm stored value.
        wr(1, 7, 8'h0F, 8'hFF);
        rd1(1, 7, 8'hFF, 8'h0F);
        step();
        rd0(1, 7, 8'hF0, 8'h00);
        rd1(1, 7, 8'hFF, 8'h0F);
        step();

        // Fill whole array with FF.
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++) begin
                wr(w, r, 8'hFF, 8'hFF);
                step();
            end

        // Clear warp 2; the write in the request cycle still lands.
        clear_req = 1'b1; clear_warp = 3'd2;
        wr(5, 3, 8'hFF, 8'h3C);
        step();
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (n == 3) begin
                wr(4, 4, 8'hFF, 8'h00);        // ignored while busy
                clear_req = 1'b1; clear_warp = 3'd0; // ignored while busy
                rd1(2, 0, 8'hFF, 8'h00);       // already cleared
                rd0(7, 0, 8'hFF, 8'hFF);       // reads serviced while busy
            end
            step();
            n++;
        end
        check_int("clear_busy_cycles", n, 32);
        step();
        check_int("idle_after_clear", int'(busy), 0);

        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++) begin
                if (w == 2)               rd0(w, r, 8'hFF, 8'h00);
                else if (w == 5 && r == 3) rd0(w, r, 8'hFF, 8'h3C);
                else                      rd0(w, r, 8'hFF, 8'hFF);
                step();
            end

        // Both ports, same entry, partial enable.
        rd0(6, 31, 8'h3C, 8'h3C);
        rd1(6, 31, 8'h3C, 8'h3C);
        step();

        // Reset in the middle of a single-warp clear.
        clear_req = 1'b1; clear_warp = 3'd0;
        step();
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        read_en_0 = 8'hFF; rwarp_0 = 3'd7; raddr_0 = 5'd1; // must not produce rvalid
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1 || rvalid_0 !== 1'b0 || rdata_0 !== 8'h00) begin
            errors++;
            $display("FAIL midclear_reset_state: busy=%b rv0=%b rd0=%h, want 1/0/00", busy, rvalid_0, rdata_0);
        end
        busy_cycles(n);
        check_int("reinit_busy_cycles", n, 256);
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++) begin
                rd0(w, r, 8'hFF, 8'h00);
                rd1(7 - w, 31 - r, 8'hFF, 8'h00);
                step();
            end

        step();
        step();
        step();
        check_int("pending_reads_port0", q0.size(), 0);
        check_int("pending_reads_port1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
